// File: rtl/smag_accum_pkg.sv
// Shared widths for the sign-magnitude accumulate stage of the receiver MAC path.
package smag_accum_pkg;

    // Datapath word length (sign bit plus Q(N-1) fractional magnitude).
    localparam int REG_WORD_LEN  = 16;
    // Extra integer bits carried by the internal accumulator.
    localparam int ACC_GUARD_LEN = 8;
    // Width of the per-block term counter.
    localparam int ACC_CNT_LEN   = 8;

endpackage

// File: rtl/smag_sat_pack.sv
// Combinational packer: two's-complement accumulator value -> saturated
// N-bit sign-magnitude word, with a flag when the magnitude had to be clipped.
module smag_sat_pack
    import smag_accum_pkg::*;
#(
    parameter int N     = REG_WORD_LEN,
    parameter int GUARD = ACC_GUARD_LEN
) (
    input  logic [N+GUARD-1:0] acc_i,
    output logic [N-1:0]       smag_o,
    output logic               clip_o
);

    localparam int W = N + GUARD;

    logic         neg;
    logic [W-1:0] abs_v;
    logic [N-2:0] mag;

    // Absolute value, clip to the largest Q(N-1) magnitude, and force +0 for zero.
    always_comb begin
        neg    = acc_i[W-1];
        abs_v  = neg ? (~acc_i + W'(1)) : acc_i;
        // Any set bit at or above N-1 means |acc| exceeds 2^(N-1)-1.
        clip_o = |abs_v[W-1:N-1];
        mag    = clip_o ? {(N-1){1'b1}} : abs_v[N-2:0];
        smag_o = {neg & (mag != '0), mag};
    end

endmodule

// File: rtl/smag_accum.sv
// Block accumulator for sign-magnitude products.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; ready never depends combinationally on the opposite side's valid/ready,
// and a producer holds its payload stable while valid is high and ready is low.
module smag_accum
    import smag_accum_pkg::*;
#(
    parameter int N     = REG_WORD_LEN,
    parameter int GUARD = ACC_GUARD_LEN,
    parameter int CNT_W = ACC_CNT_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count,
    output logic             dbg_state_o
);

    localparam int W = N + GUARD;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    // Symmetric accumulator limits: +(2^(W-1)-1) and -(2^(W-1)-1).
    localparam logic [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ACC_MIN = {1'b1, {(W-2){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stk_q, stk_d;
    logic [N-1:0]     out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic [W-1:0]     mag_ext;
    logic [W-1:0]     term;
    logic [W:0]       sum_wide;
    logic             pos_ovf;
    logic             neg_clip;
    logic             add_sat;
    logic [W-1:0]     acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic [N-1:0]     pack_smag;
    logic             pack_clip;

    // Sign-magnitude to two's complement plus a guarded, saturating add.
    always_comb begin
        mag_ext  = {{(GUARD + 1){1'b0}}, in_data[N-2:0]};
        // A zero magnitude negates to zero, so negative zero needs no special case.
        term     = in_data[N-1] ? (~mag_ext + W'(1)) : mag_ext;
        sum_wide = {acc_q[W-1], acc_q} + {term[W-1], term};
        pos_ovf  = ~sum_wide[W] & sum_wide[W-1];
        // Negative overflow, or landing exactly on -2^(W-1), both clamp to ACC_MIN.
        neg_clip = sum_wide[W] & (~sum_wide[W-1] | (sum_wide[W-2:0] == '0));
        add_sat  = pos_ovf | neg_clip;
        if (pos_ovf) begin
            acc_sum = ACC_MAX;
        end else if (neg_clip) begin
            acc_sum = ACC_MIN;
        end else begin
            acc_sum = sum_wide[W-1:0];
        end
        cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    smag_sat_pack #(
        .N     (N),
        .GUARD (GUARD)
    ) u_pack (
        .acc_i  (acc_sum),
        .smag_o (pack_smag),
        .clip_o (pack_clip)
    );

    // Next-state: accumulate in ACC, capture the packed result on the last term,
    // hold it in DONE until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        stk_d       = stk_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        if (state_q == ST_ACC) begin
            if (in_valid) begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
                stk_d = stk_q | add_sat;
                if (in_last) begin
                    state_d     = ST_DONE;
                    out_data_d  = pack_smag;
                    out_sat_d   = stk_q | add_sat | pack_clip;
                    out_count_d = cnt_inc;
                end
            end
        end else begin
            if (out_ready) begin
                state_d = ST_ACC;
                acc_d   = '0;
                cnt_d   = '0;
                stk_d   = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            stk_q       <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            stk_q       <= stk_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready    = (state_q == ST_ACC);
    assign out_valid   = (state_q == ST_DONE);
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign out_count   = out_count_q;
    assign dbg_state_o = state_q[0];

endmodule
